// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
//   Shares one external combinational 4-bit ALU between two requesters.
//   Round-robin grant, operands latched on accept and driven to the ALU,
//   result captured one cycle later and returned on a per-requester
//   response handshake.
// Ports:
//   clk, reset                 clock (rising edge), async active-high reset
//   req_valid/req_ready [1:0]  request handshake, bit i = requester i
//   a0,b0,op0 / a1,b1,op1      operands and opcode per requester
//   rsp_valid/rsp_ready [1:0]  response handshake, bit i = requester i
//   rsp_data, rsp_err          result and illegal-opcode flag
//   alu_a, alu_b, alu_opcode   to the external ALU (from latched regs only)
//   alu_result                 from the external ALU
//   busy                       state is not IDLE
//   op_count                   completed responses, saturating
module alu_req_arbiter #(
  parameter int CNT_W   = 8,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [3:0]       a0,
  input  logic [3:0]       b0,
  input  logic [2:0]       op0,
  input  logic [3:0]       a1,
  input  logic [3:0]       b1,
  input  logic [2:0]       op1,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_err,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [7:0]       alu_result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } req_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  req_t [1:0] req_in;
  req_t       lat;
  logic       gid;   // requester owning the operation in flight
  logic       ptr;   // requester that wins a tie
  logic [1:0] gnt;

  assign req_in[0] = {a0, b0, op0};
  assign req_in[1] = {a1, b1, op1};

  // Grant is combinational in IDLE; held off during reset so req_ready
  // shows its reset value while reset is asserted.
  always_comb begin
    gnt = 2'b00;
    if (!reset && state == IDLE) begin
      case (req_valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req_ready  = gnt;
  assign alu_a      = lat.a;
  assign alu_b      = lat.b;
  assign alu_opcode = lat.op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lat       <= '0;
      gid       <= 1'b0;
      ptr       <= RR_INIT;
      rsp_valid <= 2'b00;
      rsp_data  <= 8'h00;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|gnt) begin
            lat   <= req_in[gnt[1]];
            gid   <= gnt[1];
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          // Opcodes 101..111 are undefined: the ALU output is ignored.
          if (lat.op > 3'd4) begin
            rsp_data <= 8'h00;
            rsp_err  <= 1'b1;
          end else begin
            rsp_data <= alu_result;
            rsp_err  <= 1'b0;
          end
          rsp_valid <= {gid, ~gid};
          state     <= RESP;
        end
        RESP: begin
          // Only the owner's ready bit completes the response.
          if (rsp_ready[gid]) begin
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            ptr       <= ~gid;
            if (op_count != CNT_MAX) op_count <= op_count + CNT_ONE;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;

  localparam int CNT_W   = 2;
  localparam bit RR_INIT = 1'b0;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0]       a0, b0, a1, b1, alu_a, alu_b;
  logic [2:0]       op0, op1, alu_opcode;
  logic [7:0]       rsp_data, alu_result;
  logic             rsp_err, busy;
  logic [CNT_W-1:0] op_count;

  alu_req_arbiter #(.CNT_W(CNT_W), .RR_INIT(RR_INIT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .op0(op0), .a1(a1), .b1(b1), .op1(op1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // External ALU; drives junk on undefined opcodes so masking is visible.
  always_comb begin
    alu_result = 8'hA5;
    case (alu_opcode)
      3'd0: alu_result = {3'b000, {1'b0, alu_a} + {1'b0, alu_b}};
      3'd1: alu_result = {4'h0, alu_a - alu_b};
      3'd2: alu_result = {4'h0, alu_a} * {4'h0, alu_b};
      3'd3: alu_result = {4'h0, alu_a & alu_b};
      3'd4: alu_result = {4'h0, 4'b0001 << alu_a[1:0]};
      default: alu_result = 8'hA5;
    endcase
  end

  typedef struct { int id; int data; bit err; } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0;
  bit         m_busy, m_ptr;
  int         m_cnt, m_lat;
  logic [1:0] last_ready = 2'b00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from the opcode table, in plain integer arithmetic.
  function automatic exp_t ref_rsp(input int id, input int a, input int b, input int op);
    exp_t e;
    e.id = id; e.err = 1'b0;
    case (op)
      0: e.data = a + b;
      1: e.data = (a - b + 16) % 16;
      2: e.data = a * b;
      3: e.data = a & b;
      4: e.data = 1 << (a % 4);
      default: begin e.data = 0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  // Scoreboard: grant section pushes the expected response, response
  // section pops and compares when the DUT presents one.
  int         exp_v;
  logic [1:0] eg;
  bit         rel;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_busy = 1'b0; m_ptr = RR_INIT; m_cnt = 0; m_lat = 0;
      last_ready = 2'b00;
    end else begin
      chk("op_count", int'(op_count), m_cnt);
      chk("busy", int'(busy), int'(m_busy));
      rel = 1'b0;
      if (q.size() == 0) begin
        chk("rsp_valid_idle", int'(rsp_valid), 0);
      end else begin
        exp_v = (m_lat == 0) ? 0 : (q[0].id == 1 ? 2 : 1);
        chk("rsp_valid", int'(rsp_valid), exp_v);
        if (exp_v == 0) m_lat++;
        else begin
          chk("rsp_data", int'(rsp_data), q[0].data);
          chk("rsp_err", int'(rsp_err), int'(q[0].err));
          if (rsp_ready[q[0].id]) begin
            m_ptr = (q[0].id == 0);
            if (m_cnt < CNT_MAX) m_cnt++;
            void'(q.pop_front());
            rel = 1'b1;
          end
        end
      end
      eg = 2'b00;
      if (!m_busy) begin
        if (req_valid == 2'b01) eg = 2'b01;
        else if (req_valid == 2'b10) eg = 2'b10;
        else if (req_valid == 2'b11) eg = m_ptr ? 2'b10 : 2'b01;
      end
      chk("req_ready", int'(req_ready), int'(eg));
      last_ready = req_ready;
      if (eg != 2'b00) begin
        if (eg[1]) q.push_back(ref_rsp(1, a1, b1, op1));
        else       q.push_back(ref_rsp(0, a0, b0, op0));
        m_busy = 1'b1; m_lat = 0;
      end
      if (rel) m_busy = 1'b0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int i);
    int n = 0;
    do begin cyc(1); n++; end while (!last_ready[i] && n < 60);
    if (!last_ready[i]) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin cyc(1); n++; end
    if (busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_data", int'(rsp_data), 0);
    chk("rst_rsp_err", int'(rsp_err), 0);
    chk("rst_alu_ops", int'({alu_a, alu_b, alu_opcode}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_op_count", int'(op_count), 0);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 chk_reset();
    @(negedge clk);
    cyc(1);
    reset = 1'b0;
  endtask

  task automatic rand_ops(input int i);
    if (i == 0) begin a0 = 4'($urandom); b0 = 4'($urandom); op0 = 3'($urandom); end
    else        begin a1 = 4'($urandom); b1 = 4'($urandom); op1 = 3'($urandom); end
  endtask

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog expired");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    a0 = 0; b0 = 0; op0 = 0; a1 = 0; b1 = 0; op1 = 0;
    #1 chk_reset();
    cyc(2);
    reset = 1'b0;

    // ADD 9+7 -> 0x10; operands change right after acceptance.
    rsp_ready = 2'b11;
    a0 = 9; b0 = 7; op0 = 3'd0; req_valid = 2'b01;
    wait_acc(0);
    req_valid = 2'b00; a0 = 4'hF; b0 = 4'hF; op0 = 3'd2;
    cyc(4);

    // Both requesters held across three transactions.
    a0 = 3; b0 = 5; op0 = 3'd1; a1 = 15; b1 = 15; op1 = 3'd2;
    req_valid = 2'b11;
    cyc(9);
    req_valid = 2'b00;
    wait_idle();
    cyc(1);

    // Illegal opcode from requester 1.
    a1 = 4'h6; b1 = 4'h3; op1 = 3'b110; req_valid = 2'b10;
    wait_acc(1);
    req_valid = 2'b00;
    cyc(4);

    // Back-pressure on DEC; requester 1 waits, wrong-bit ready ignored.
    rsp_ready = 2'b00;
    a0 = 4'b0010; b0 = 4'h9; op0 = 3'd4; req_valid = 2'b01;
    wait_acc(0);
    a1 = 4'h2; b1 = 4'h3; op1 = 3'd0; req_valid = 2'b10;
    cyc(1);
    rsp_ready = 2'b10;
    cyc(5);
    rsp_ready = 2'b01;
    wait_acc(1);
    rsp_ready = 2'b11; req_valid = 2'b00;
    cyc(4);

    // Leave priority on requester 1, then reset during EXEC.
    a0 = 1; b0 = 1; op0 = 3'd3; req_valid = 2'b01;
    wait_acc(0);
    req_valid = 2'b00;
    cyc(3);
    req_valid = 2'b01;
    wait_acc(0);
    req_valid = 2'b00;
    pulse_reset();
    rsp_ready = 2'b00;
    a1 = 7; b1 = 2; op1 = 3'd1; req_valid = 2'b11;
    wait_acc(RR_INIT);
    req_valid = 2'b00;
    cyc(1);
    chk("resp_before_reset", int'(rsp_valid != 2'b00), 1);
    pulse_reset();
    rsp_ready = 2'b11;
    cyc(5);

    // Randomized traffic; requesters hold operands until accepted.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && last_ready[i]) begin
          rand_ops(i);
          req_valid[i] = ($urandom_range(0, 2) != 0);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          rand_ops(i);
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom_range(0, 3));
      cyc(1);
    end
    req_valid = 2'b00; rsp_ready = 2'b11;
    cyc(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
